lut_mult_sequencer: RTL
=======================

LUT_MULT_SEQUENCER -- requirements
Module: lut_mult_sequencer

Interface
REQ-001 Clock and reset are decided: one clock `clk`, and reset `rst_n`, which is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  operand pair offered.
REQ-005 in_ready  output  1  block can accept operands; high only in IDLE.
REQ-006 a  input  16  unsigned multiplicand, sampled on acceptance.
REQ-007 b  input  16  unsigned multiplier, sampled on acceptance.
REQ-008 out_valid  output  1  product valid; high only in DONE.
REQ-009 out_ready  input  1  consumer accepts the product.
REQ-010 product  output  32  unsigned a*b; held stable while out_valid=1.
REQ-011 busy  output  1  high in BUILD or MULT.

Function
REQ-012 Acceptance occurs on a rising edge with in_valid=1 and in_ready=1; a and b are captured, table entry T[1]=a, and the FSM moves IDLE->BUILD.
REQ-013 FSM states are IDLE, BUILD, MULT and DONE; encoding is free.
REQ-014 BUILD lasts exactly 7 cycles and computes T[k]=T[k-1]+a for k=2..8, one addition per cycle.
REQ-015 Each T entry is 19 bits (max 8*0xFFFF=0x7FFF8); additions never overflow.
REQ-016 BUILD->MULT follows the cycle that writes T[8].
REQ-017 MULT processes digit i=0..4, one digit per cycle; carry c0=0.
REQ-018 For i=0..3, let t=b[4i+3:4i]+ci; if t>=8 then sign=1, mag=16-t, ci+1=1; otherwise sign=0, mag=t, ci+1=0.
REQ-019 For i=4, t=c4, sign=0 and mag=c4.
REQ-020 Per digit, acc = acc + (sign ? -(T[mag]<<4i) : (T[mag]<<4i)), with T[0]=0; acc is at least 36 bits in two's complement and is cleared on acceptance.
REQ-021 After digit 4, MULT->DONE and product=acc[31:0]; the final acc is non-negative and below 2^32.
REQ-022 Without the macro, out_valid rises exactly 12 rising edges after the acceptance edge.
REQ-023 In DONE, product and out_valid hold until out_ready=1; that edge moves DONE->IDLE, so in_ready=1 in the following cycle.
REQ-024 A new acceptance cannot occur in the cycle out_valid drops, because in_ready is registered from state.
REQ-025 in_valid is ignored outside IDLE; a, b and out_ready are ignored outside their respective states.
REQ-026 Boundary inputs need no special case: a=0 or b=0 gives product 0 with normal latency; t=16 gives mag=0, sign=1, carry=1, contributing 0.

Reset
REQ-027 On rst_n=0, asynchronously: state=IDLE, in_ready=1 after deassertion, out_valid=0, busy=0, product=0, acc=0, all T=0, carry=0.
REQ-028 Reset asserted in any state aborts the operation; no partial product is ever presented.

Configuration
REQ-029 Macro LUT_MULT_EARLY_EXIT_EN, when defined, adds early exit: after digit i in MULT, if all remaining nibbles of b above i and ci+1 are zero, go directly to DONE.
REQ-030 With LUT_MULT_EARLY_EXIT_EN, at least one MULT cycle always occurs, and latency is 8+i rising edges, i being the last processed digit.
REQ-031 Without LUT_MULT_EARLY_EXIT_EN, all 5 digits are always processed.
REQ-032 Product values are identical with and without LUT_MULT_EARLY_EXIT_EN.

Verification
REQ-033 a=3, b=5, out_ready=1 -> product=0x0000000F, out_valid 12 edges after acceptance (macro off).
REQ-034 a=0xFFFF, b=0xFFFF -> product=0xFFFE0001; digits recode to sign=1, mag=1 on digit 0 and carry propagates into digit 4.
REQ-035 a=2, b=0x0009 -> digit 0 recodes to -7 with carry 1 -> product=0x00000012; with the macro, out_valid comes 9 edges after acceptance.
REQ-036 a=0x1234, b=0x0010, out_ready held 0 for 5 cycles in DONE -> product=0x00012340 stable, out_valid=1, in_ready=0 throughout; in_ready=1 the cycle after out_ready=1.
REQ-037 rst_n pulsed low during MULT of a=7, b=7 -> all outputs reset immediately; the next operation a=7, b=7 -> product=0x31 with no residue.
REQ-038 Macro on, b=0x0001, a=0xABCD -> product=0x0000ABCD, out_valid 8 edges after acceptance.

Source files
------------

// File: rtl/lut_mult_sequencer.sv
// Sequential 16x16 unsigned multiplier: builds a radix-16 multiple table T[1..8] of 'a',
// then accumulates signed-recoded nibbles of 'b'. Optional macro LUT_MULT_EARLY_EXIT_EN.
module lut_mult_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] product,
    output logic        busy
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUILD = 2'd1;
    localparam logic [1:0] S_MULT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [15:0]        a_q, a_d;
    logic [15:0]        b_q, b_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic signed [35:0] acc_q, acc_d;
    logic [18:0]        tbl_q [1:8];
    logic [18:0]        tbl_d [1:8];

    logic [3:0]         nib;
    logic [5:0]         rc;
    logic               dsign;
    logic [3:0]         dmag;
    logic               dcarry;
    logic [18:0]        sel;
    logic signed [35:0] term;
`ifdef LUT_MULT_EARLY_EXIT_EN
    logic [15:0]        rem;
`endif
    logic               unused_acc_hi;

    // Returns {sign, mag[3:0], carry_out} for one nibble plus incoming carry.
    function automatic logic [5:0] recode(input logic [3:0] n, input logic cin);
        logic [4:0] t;
        logic [4:0] m;
        t = {1'b0, n} + {4'b0, cin};
        m = 5'd16 - t;
        if (t >= 5'd8) recode = {1'b1, m[3:0], 1'b1};
        else           recode = {1'b0, t[3:0], 1'b0};
    endfunction

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        acc_d   = acc_q;
        for (int k = 1; k <= 8; k++) tbl_d[k] = tbl_q[k];

        nib = b_q[{cnt_q[1:0], 2'b00} +: 4];
        rc  = recode(nib, carry_q);
        // Digit 4 only absorbs the final carry.
        if (cnt_q == 4'd4) begin
            dsign  = 1'b0;
            dmag   = {3'b000, carry_q};
            dcarry = 1'b0;
        end else begin
            dsign  = rc[5];
            dmag   = rc[4:1];
            dcarry = rc[0];
        end

        sel = 19'd0;
        for (int k = 1; k <= 8; k++) begin
            if (dmag == 4'(k)) sel = tbl_q[k];
        end
        term = $signed({17'd0, sel} << {cnt_q[2:0], 2'b00});
`ifdef LUT_MULT_EARLY_EXIT_EN
        rem = b_q >> {cnt_q[2:0] + 3'd1, 2'b00};
`endif

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    tbl_d[1] = {3'b000, a};
                    acc_d    = '0;
                    carry_d  = 1'b0;
                    cnt_d    = 4'd2;
                    state_d  = S_BUILD;
                end
            end
            S_BUILD: begin
                for (int k = 2; k <= 8; k++) begin
                    if (cnt_q == 4'(k)) tbl_d[k] = tbl_q[k-1] + {3'b000, a_q};
                end
                if (cnt_q == 4'd8) begin
                    cnt_d   = 4'd0;
                    state_d = S_MULT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_MULT: begin
                acc_d   = dsign ? (acc_q - term) : (acc_q + term);
                carry_d = dcarry;
                if (cnt_q == 4'd4) begin
                    state_d = S_DONE;
`ifdef LUT_MULT_EARLY_EXIT_EN
                end else if (rem == 16'd0 && !dcarry) begin
                    state_d = S_DONE;
`endif
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                if (out_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            acc_q   <= '0;
            for (int k = 1; k <= 8; k++) tbl_q[k] <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            acc_q   <= acc_d;
            for (int k = 1; k <= 8; k++) tbl_q[k] <= tbl_d[k];
        end
    end

    // The final accumulator is always a non-negative 32-bit value.
    assign unused_acc_hi = ^acc_q[35:32];
    assign product       = acc_q[31:0];
    assign in_ready      = (state_q == S_IDLE);
    assign out_valid     = (state_q == S_DONE);
    assign busy          = (state_q == S_BUILD) || (state_q == S_MULT);
endmodule
